// File: rtl/sys_ctrl_pkg.sv
// Shared command codes and controller state encoding for the UART TX-side system controller.
package sys_ctrl_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_ALU   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_ALU_WAIT,
        ST_SEND_OFFER,
        ST_SEND_DRAIN
    } sc_state_t;

    function automatic logic cmd_legal(input logic [2:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ) || (cmd == CMD_ALU);
    endfunction

endpackage

// File: rtl/sys_ctrl_tx_if.sv
// Command, register-file, ALU and UART TX signals of the system controller.
interface sys_ctrl_tx_if #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int RES_BYTES = 2,
    parameter int FUN_W     = 4
);
    logic [2:0]                  SC_Cmd;
    logic                        SC_Cmd_Valid;
    logic [DATA_W-1:0]           SC_Pdata;
    logic [ADDR_W-1:0]           SC_Addr;
    logic [DATA_W-1:0]           SC_RdData;
    logic                        SC_RF_Valid;
    logic [RES_BYTES*DATA_W-1:0] SC_ALU_Out;
    logic                        SC_ALU_Valid;
    logic                        SC_TX_Busy;
    logic [ADDR_W-1:0]           SC_Addr_Out;
    logic [DATA_W-1:0]           SC_Wr_Data;
    logic                        SC_Wr_En;
    logic                        SC_Rd_En;
    logic [FUN_W-1:0]            SC_ALU_Fun;
    logic                        SC_ALU_En;
    logic                        SC_Gate_En;
    logic [DATA_W-1:0]           SC_TX_Pdata;
    logic                        SC_TX_Valid;
    logic                        SC_Cmd_Err;
    logic                        SC_Idle;

    modport master (
        input  SC_Cmd, SC_Cmd_Valid, SC_Pdata, SC_Addr, SC_RdData, SC_RF_Valid,
               SC_ALU_Out, SC_ALU_Valid, SC_TX_Busy,
        output SC_Addr_Out, SC_Wr_Data, SC_Wr_En, SC_Rd_En, SC_ALU_Fun, SC_ALU_En,
               SC_Gate_En, SC_TX_Pdata, SC_TX_Valid, SC_Cmd_Err, SC_Idle
    );

    modport slave (
        output SC_Cmd, SC_Cmd_Valid, SC_Pdata, SC_Addr, SC_RdData, SC_RF_Valid,
               SC_ALU_Out, SC_ALU_Valid, SC_TX_Busy,
        input  SC_Addr_Out, SC_Wr_Data, SC_Wr_En, SC_Rd_En, SC_ALU_Fun, SC_ALU_En,
               SC_Gate_En, SC_TX_Pdata, SC_TX_Valid, SC_Cmd_Err, SC_Idle
    );

endinterface

// File: rtl/sc_byte_serialiser.sv
// Holds a multi-byte result and hands it to the UART TX one byte at a time, LS byte first,
// using an offer / drain handshake on the TX busy flag.
module sc_byte_serialiser
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int RES_BYTES = 2,
    localparam int RES_W    = RES_BYTES * DATA_W,
    localparam int CW       = $clog2(RES_BYTES + 1)
)
(
    input  logic              SC_CLK,
    input  logic              SC_RST,
    input  logic              start,
    input  logic [CW-1:0]     count,
    input  logic [RES_W-1:0]  din,
    input  logic              tx_busy,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_pdata,
    output logic              done,
    output sc_state_t         phase_nxt
);

    sc_state_t         phase_q, phase_d;
    logic [RES_W-1:0]  res_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     idx_q;
    logic [DATA_W-1:0] byte_sel;
    logic              last;

    assign last = ((idx_q + CW'(1)) == count_q);

    always_comb begin
        phase_d = phase_q;
        done    = 1'b0;
        case (phase_q)
            ST_IDLE:       if (start) phase_d = ST_SEND_OFFER;
            ST_SEND_OFFER: if (tx_busy) phase_d = ST_SEND_DRAIN;
            ST_SEND_DRAIN: begin
                if (!tx_busy) begin
                    if (last) begin
                        phase_d = ST_IDLE;
                        done    = 1'b1;
                    end else begin
                        phase_d = ST_SEND_OFFER;
                    end
                end
            end
            default:       phase_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SC_CLK or negedge SC_RST) begin
        if (!SC_RST) begin
            phase_q <= ST_IDLE;
            res_q   <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            phase_q <= phase_d;
            if (start) begin
                res_q   <= din;
                count_q <= count;
                idx_q   <= '0;
            end else if (phase_q == ST_SEND_DRAIN && !tx_busy) begin
                idx_q <= last ? '0 : idx_q + CW'(1);
            end
        end
    end

    always_comb begin
        byte_sel = '0;
        for (int i = 0; i < RES_BYTES; i++) begin
            if (idx_q == CW'(i)) byte_sel = res_q[i*DATA_W +: DATA_W];
        end
    end

    assign tx_valid  = (phase_q == ST_SEND_OFFER);
    assign tx_pdata  = tx_valid ? byte_sel : '0;
    assign phase_nxt = phase_d;

endmodule

// File: rtl/sys_ctrl_tx.sv
// UART TX-side system controller: executes RF write/read and ALU commands and returns
// read/ALU results over the UART transmitter, with illegal-command and wait-timeout errors.
//
// state         | meaning
// IDLE          | ready for a command when TX is not busy
// WRITE         | one-cycle RF write strobe
// READ_WAIT     | RF read strobe held until read data valid or timeout
// ALU_WAIT      | ALU enable held until result valid or timeout
// SEND_OFFER    | result byte offered to TX, waiting for busy
// SEND_DRAIN    | waiting for TX to finish the byte
module sys_ctrl_tx
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int RES_BYTES = 2,
    parameter int FUN_W     = 4,
    parameter int TIMEOUT   = 255
)
(
    input logic           SC_CLK,
    input logic           SC_RST,
    sys_ctrl_tx_if.master bus
);

    localparam int RES_W = RES_BYTES * DATA_W;
    localparam int CW    = $clog2(RES_BYTES + 1);
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sc_state_t         state_q, state_d, ser_phase_nxt;
    logic [2:0]        cmd_q;
    logic [DATA_W-1:0] pdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [TW-1:0]     wait_q;
    logic              err_q, err_d;
    logic              accept, wait_exp, in_wait, sending;
    logic              ser_start, ser_done;
    logic [CW-1:0]     ser_count;
    logic [RES_W-1:0]  ser_din;

    assign bus.SC_Idle = (state_q == ST_IDLE) && !bus.SC_TX_Busy;
    assign accept      = bus.SC_Idle && bus.SC_Cmd_Valid;
    assign in_wait     = (state_q == ST_READ_WAIT) || (state_q == ST_ALU_WAIT);
    assign sending     = (state_q == ST_SEND_OFFER) || (state_q == ST_SEND_DRAIN);
    // Down-counter loaded on acceptance; reaching zero in a wait state without a valid is the timeout.
    assign wait_exp    = (wait_q == '0);

    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        ser_start = 1'b0;
        ser_count = '0;
        ser_din   = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!cmd_legal(bus.SC_Cmd))        err_d   = 1'b1;
                    else if (bus.SC_Cmd == CMD_WRITE)  state_d = ST_WRITE;
                    else if (bus.SC_Cmd == CMD_READ)   state_d = ST_READ_WAIT;
                    else                               state_d = ST_ALU_WAIT;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ_WAIT: begin
                if (bus.SC_RF_Valid) begin
                    ser_start = 1'b1;
                    ser_count = CW'(1);
                    ser_din   = RES_W'(bus.SC_RdData);
                    state_d   = ST_SEND_OFFER;
                end else if (wait_exp) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ALU_WAIT: begin
                if (bus.SC_ALU_Valid) begin
                    ser_start = 1'b1;
                    ser_count = CW'(RES_BYTES);
                    ser_din   = bus.SC_ALU_Out;
                    state_d   = ST_SEND_OFFER;
                end else if (wait_exp) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_SEND_OFFER, ST_SEND_DRAIN: state_d = ser_done ? ST_IDLE : ser_phase_nxt;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SC_CLK or negedge SC_RST) begin
        if (!SC_RST) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            cmd_q   <= '0;
            pdata_q <= '0;
            addr_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (accept) begin
                cmd_q   <= bus.SC_Cmd;
                pdata_q <= bus.SC_Pdata;
                addr_q  <= bus.SC_Addr;
                wait_q  <= TW'(TIMEOUT - 1);
            end else if (in_wait && !wait_exp) begin
                wait_q <= wait_q - TW'(1);
            end
        end
    end

    sc_byte_serialiser #(
        .DATA_W    (DATA_W),
        .RES_BYTES (RES_BYTES)
    ) u_ser (
        .SC_CLK    (SC_CLK),
        .SC_RST    (SC_RST),
        .start     (ser_start),
        .count     (ser_count),
        .din       (ser_din),
        .tx_busy   (bus.SC_TX_Busy),
        .tx_valid  (bus.SC_TX_Valid),
        .tx_pdata  (bus.SC_TX_Pdata),
        .done      (ser_done),
        .phase_nxt (ser_phase_nxt)
    );

    assign bus.SC_Wr_En    = (state_q == ST_WRITE);
    assign bus.SC_Rd_En    = (state_q == ST_READ_WAIT);
    assign bus.SC_ALU_En   = (state_q == ST_ALU_WAIT);
    assign bus.SC_Wr_Data  = bus.SC_Wr_En ? pdata_q : '0;
    assign bus.SC_Addr_Out = (bus.SC_Wr_En || bus.SC_Rd_En) ? addr_q : '0;
    assign bus.SC_ALU_Fun  = bus.SC_ALU_En ? pdata_q[FUN_W-1:0] : '0;
    assign bus.SC_Gate_En  = bus.SC_ALU_En || (sending && cmd_q == CMD_ALU);
    assign bus.SC_Cmd_Err  = err_q;

endmodule

// File: tb/tb_sys_ctrl_tx.sv
// Directed bench for sys_ctrl_tx: a command vector table on a 2-byte-result instance
// (TIMEOUT=16) plus hand sequences for a 3-byte instance and reset during a send.
module tb_sys_ctrl_tx;
    import sys_ctrl_pkg::*;

    localparam int BUSY_LEN = 10;
    localparam int WINDOW   = 70;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sys_ctrl_tx_if #(.DATA_W(8), .ADDR_W(8), .RES_BYTES(2), .FUN_W(4)) if_a ();
    sys_ctrl_tx_if #(.DATA_W(8), .ADDR_W(8), .RES_BYTES(3), .FUN_W(4)) if_b ();

    sys_ctrl_tx #(.DATA_W(8), .ADDR_W(8), .RES_BYTES(2), .FUN_W(4), .TIMEOUT(16)) u_a (
        .SC_CLK (clk), .SC_RST (rst_n), .bus (if_a)
    );
    sys_ctrl_tx #(.DATA_W(8), .ADDR_W(8), .RES_BYTES(3), .FUN_W(4), .TIMEOUT(255)) u_b (
        .SC_CLK (clk), .SC_RST (rst_n), .bus (if_b)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [7:0]  addr;
        logic [7:0]  pdata;
        int          dly;      // cycle of the RF/ALU valid after acceptance; 0 = never
        logic [15:0] resp;
        int          e_wr;
        int          e_rd;
        int          e_alu;
        logic [3:0]  e_fun;
        int          e_nb;
        logic [15:0] e_bytes;
        int          e_err_t;  // cycle of the error pulse; 0 = none
        logic        e_gate;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while (!if_a.SC_Idle && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_before"}, 32'(if_a.SC_Idle), 1);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int wr_n = 0, rd_n = 0, alu_n = 0, nb = 0, err_n = 0, err_t = 0, wr_t = 0;
        int tx_t0 = 0, tx_t1 = 0, busy_cnt = 0;
        int fun_bad = 0, gate_bad = 0, hs_bad = 0, addr_bad = 0;
        logic [7:0] bytes [2];
        logic [7:0] wr_a = 8'h0, wr_d = 8'h0;
        logic idle1 = 1'b0, idle2 = 1'b0;
        bytes[0] = 8'h0;
        bytes[1] = 8'h0;
        wait_idle_a(tag);
        if_a.SC_Cmd       = v.cmd;
        if_a.SC_Addr      = v.addr;
        if_a.SC_Pdata     = v.pdata;
        if_a.SC_Cmd_Valid = 1'b1;
        @(negedge clk);
        if_a.SC_Cmd_Valid = 1'b0;
        for (int t = 1; t <= WINDOW; t++) begin
            if (t == 1) idle1 = if_a.SC_Idle;
            if (t == 2) idle2 = if_a.SC_Idle;
            if (if_a.SC_Wr_En) begin
                wr_n++;
                if (wr_t == 0) wr_t = t;
                wr_a = if_a.SC_Addr_Out;
                wr_d = if_a.SC_Wr_Data;
            end
            if (if_a.SC_Rd_En) begin
                rd_n++;
                if (if_a.SC_Addr_Out != v.addr) addr_bad++;
            end
            if (if_a.SC_ALU_En) begin
                alu_n++;
                if (if_a.SC_ALU_Fun != v.e_fun) fun_bad++;
                if (!if_a.SC_Gate_En) gate_bad++;
            end
            if (if_a.SC_Cmd_Err) begin
                err_n++;
                if (err_t == 0) err_t = t;
            end
            if (if_a.SC_Cmd_Err && if_a.SC_TX_Valid) hs_bad++;
            if (if_a.SC_TX_Valid && if_a.SC_TX_Busy) hs_bad++;
            if ((if_a.SC_TX_Valid || if_a.SC_TX_Busy) && if_a.SC_Gate_En != v.e_gate) gate_bad++;
            // UART model: accepts an offered byte and stays busy for BUSY_LEN cycles
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) if_a.SC_TX_Busy = 1'b0;
            end else if (if_a.SC_TX_Valid) begin
                if (nb < 2) bytes[nb] = if_a.SC_TX_Pdata;
                if (nb == 0) tx_t0 = t;
                else if (nb == 1) tx_t1 = t;
                nb++;
                if_a.SC_TX_Busy = 1'b1;
                busy_cnt = BUSY_LEN;
            end
            if_a.SC_RdData    = v.resp[7:0];
            if_a.SC_ALU_Out   = v.resp;
            if_a.SC_RF_Valid  = (v.cmd == CMD_READ) && (v.dly == t);
            if_a.SC_ALU_Valid = (v.cmd == CMD_ALU) && (v.dly == t);
            @(negedge clk);
        end
        chk({tag, "_wr_cycles"}, 32'(wr_n), 32'(v.e_wr));
        if (v.e_wr > 0) begin
            chk({tag, "_wr_cycle"}, 32'(wr_t), 1);
            chk({tag, "_wr_addr"}, 32'(wr_a), 32'(v.addr));
            chk({tag, "_wr_data"}, 32'(wr_d), 32'(v.pdata));
            chk({tag, "_idle_n1"}, 32'(idle1), 0);
            chk({tag, "_idle_n2"}, 32'(idle2), 1);
        end
        chk({tag, "_rd_cycles"}, 32'(rd_n), 32'(v.e_rd));
        chk({tag, "_rd_addr_bad"}, 32'(addr_bad), 0);
        chk({tag, "_alu_cycles"}, 32'(alu_n), 32'(v.e_alu));
        chk({tag, "_alu_fun_bad"}, 32'(fun_bad), 0);
        chk({tag, "_tx_bytes"}, 32'(nb), 32'(v.e_nb));
        if (v.e_nb >= 1) begin
            chk({tag, "_byte0"}, 32'(bytes[0]), 32'(v.e_bytes[7:0]));
            chk({tag, "_tx_first_cycle"}, 32'(tx_t0), 32'(v.dly + 1));
        end
        if (v.e_nb >= 2) begin
            chk({tag, "_byte1"}, 32'(bytes[1]), 32'(v.e_bytes[15:8]));
            chk({tag, "_tx_second_cycle"}, 32'(tx_t1), 32'(v.dly + 1 + BUSY_LEN + 1));
        end
        chk({tag, "_err_pulses"}, 32'(err_n), (v.e_err_t != 0) ? 1 : 0);
        chk({tag, "_err_cycle"}, 32'(err_t), 32'(v.e_err_t));
        chk({tag, "_gate_bad"}, 32'(gate_bad), 0);
        chk({tag, "_handshake_bad"}, 32'(hs_bad), 0);
        chk({tag, "_idle_after"}, 32'(if_a.SC_Idle), 1);
    endtask

    task automatic seq_three_bytes();
        int nb = 0, busy_cnt = 0;
        logic [7:0] got [3];
        got[0] = 8'h0; got[1] = 8'h0; got[2] = 8'h0;
        chk("b3_idle_before", 32'(if_b.SC_Idle), 1);
        if_b.SC_Cmd       = CMD_ALU;
        if_b.SC_Pdata     = 8'h01;
        if_b.SC_Cmd_Valid = 1'b1;
        @(negedge clk);
        if_b.SC_Cmd_Valid = 1'b0;
        if_b.SC_ALU_Out   = 24'hABCDEF;
        if_b.SC_ALU_Valid = 1'b1;
        @(negedge clk);
        if_b.SC_ALU_Valid = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) if_b.SC_TX_Busy = 1'b0;
            end else if (if_b.SC_TX_Valid) begin
                if (nb < 3) got[nb] = if_b.SC_TX_Pdata;
                nb++;
                if_b.SC_TX_Busy = 1'b1;
                busy_cnt = 3;
            end
            @(negedge clk);
        end
        chk("b3_count", 32'(nb), 3);
        chk("b3_byte0", 32'(got[0]), 32'h EF);
        chk("b3_byte1", 32'(got[1]), 32'h CD);
        chk("b3_byte2", 32'(got[2]), 32'h AB);
        chk("b3_idle_after", 32'(if_b.SC_Idle), 1);
    endtask

    task automatic seq_reset_mid_send();
        int nb = 0, busy_cnt = 0, n = 0, late_valid = 0;
        logic seen_second = 1'b0;
        vec_t w;
        wait_idle_a("rst");
        if_a.SC_Cmd       = CMD_ALU;
        if_a.SC_Pdata     = 8'h03;
        if_a.SC_Cmd_Valid = 1'b1;
        @(negedge clk);
        if_a.SC_Cmd_Valid = 1'b0;
        if_a.SC_ALU_Out   = 16'h12F4;
        if_a.SC_ALU_Valid = 1'b1;
        @(negedge clk);
        if_a.SC_ALU_Valid = 1'b0;
        while (!seen_second && n < 60) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) if_a.SC_TX_Busy = 1'b0;
            end else if (if_a.SC_TX_Valid) begin
                if (nb == 1) seen_second = 1'b1;
                else begin
                    nb++;
                    if_a.SC_TX_Busy = 1'b1;
                    busy_cnt = 4;
                end
            end
            if (!seen_second) begin
                @(negedge clk);
                n++;
            end
        end
        chk("rst_second_offer_seen", 32'(seen_second), 1);
        chk("rst_second_offer_byte", 32'(if_a.SC_TX_Pdata), 32'h12);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tx_valid", 32'(if_a.SC_TX_Valid), 0);
        chk("rst_tx_pdata", 32'(if_a.SC_TX_Pdata), 0);
        chk("rst_gate_en", 32'(if_a.SC_Gate_En), 0);
        chk("rst_strobes", {28'h0, if_a.SC_Wr_En, if_a.SC_Rd_En, if_a.SC_ALU_En, if_a.SC_Cmd_Err}, 0);
        chk("rst_buses", {if_a.SC_Addr_Out, if_a.SC_Wr_Data, 4'h0, if_a.SC_ALU_Fun}, 0);
        chk("rst_idle_free", 32'(if_a.SC_Idle), 1);
        if_a.SC_TX_Busy = 1'b1;
        #1;
        chk("rst_idle_busy", 32'(if_a.SC_Idle), 0);
        if_a.SC_TX_Busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (if_a.SC_TX_Valid) late_valid++;
        end
        chk("rst_no_tx_after", 32'(late_valid), 0);
        chk("rst_idle_after_release", 32'(if_a.SC_Idle), 1);
        w = '{3'b001, 8'h42, 8'h99, 0, 16'h0, 1, 0, 0, 4'h0, 0, 16'h0, 0, 1'b0};
        run_txn(w, "rst_write");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              cmd     addr   pdata dly  resp      wr rd  alu fun   nb bytes     err_t gate
        vecs[0]  = '{3'b001, 8'h05, 8'hA7, 0,  16'h0000, 1, 0,  0,  4'h0, 0, 16'h0000, 0,  1'b0};
        vecs[1]  = '{3'b010, 8'h03, 8'h00, 3,  16'h003C, 0, 3,  0,  4'h0, 1, 16'h003C, 0,  1'b0};
        vecs[2]  = '{3'b100, 8'h00, 8'h02, 2,  16'h12F4, 0, 0,  2,  4'h2, 2, 16'h12F4, 0,  1'b1};
        vecs[3]  = '{3'b111, 8'h00, 8'h00, 0,  16'h0000, 0, 0,  0,  4'h0, 0, 16'h0000, 1,  1'b0};
        vecs[4]  = '{3'b001, 8'hFF, 8'h5A, 0,  16'h0000, 1, 0,  0,  4'h0, 0, 16'h0000, 0,  1'b0};
        vecs[5]  = '{3'b010, 8'h80, 8'h00, 1,  16'h00FF, 0, 1,  0,  4'h0, 1, 16'h00FF, 0,  1'b0};
        vecs[6]  = '{3'b100, 8'h00, 8'hFB, 5,  16'h00A5, 0, 0,  5,  4'hB, 2, 16'h00A5, 0,  1'b1};
        vecs[7]  = '{3'b000, 8'h00, 8'h00, 0,  16'h0000, 0, 0,  0,  4'h0, 0, 16'h0000, 1,  1'b0};
        vecs[8]  = '{3'b010, 8'h11, 8'h00, 16, 16'hAB77, 0, 16, 0,  4'h0, 1, 16'h0077, 0,  1'b0};
        vecs[9]  = '{3'b010, 8'h22, 8'h00, 0,  16'h0000, 0, 16, 0,  4'h0, 0, 16'h0000, 17, 1'b0};
        vecs[10] = '{3'b100, 8'h00, 8'h07, 0,  16'h0000, 0, 0,  16, 4'h7, 0, 16'h0000, 17, 1'b1};
        vecs[11] = '{3'b011, 8'h00, 8'h00, 0,  16'h0000, 0, 0,  0,  4'h0, 0, 16'h0000, 1,  1'b0};

        rst_n = 1'b0;
        if_a.SC_Cmd = '0; if_a.SC_Cmd_Valid = 1'b0; if_a.SC_Pdata = '0; if_a.SC_Addr = '0;
        if_a.SC_RdData = '0; if_a.SC_RF_Valid = 1'b0; if_a.SC_ALU_Out = '0;
        if_a.SC_ALU_Valid = 1'b0; if_a.SC_TX_Busy = 1'b0;
        if_b.SC_Cmd = '0; if_b.SC_Cmd_Valid = 1'b0; if_b.SC_Pdata = '0; if_b.SC_Addr = '0;
        if_b.SC_RdData = '0; if_b.SC_RF_Valid = 1'b0; if_b.SC_ALU_Out = '0;
        if_b.SC_ALU_Valid = 1'b0; if_b.SC_TX_Busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_idle", 32'(if_a.SC_Idle), 1);
        chk("reset_outputs", {27'h0, if_a.SC_TX_Valid, if_a.SC_Wr_En, if_a.SC_Rd_En,
                              if_a.SC_ALU_En, if_a.SC_Cmd_Err}, 0);
        chk("reset_gate", 32'(if_a.SC_Gate_En), 0);
        if_a.SC_TX_Busy = 1'b1;
        #1;
        chk("reset_idle_busy", 32'(if_a.SC_Idle), 0);
        if_a.SC_TX_Busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i], $sformatf("v%0d", i));
        end

        seq_three_bytes();
        seq_reset_mid_send();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_tx.md
# sys_ctrl_tx

Parametrised successor to the fixed 8-bit UART TX-side system controller. It accepts decoded frame commands from the RX path and performs register-file writes, register-file reads, or ALU operations. It serialises any multi-byte result to the UART transmitter one byte at a time under a busy-based handshake. New over the previous generation: configurable data, address and result widths; an N-byte result serialiser; an illegal-command flag; and a watchdog timeout on RF/ALU waits.

## Interface
- DATA_W, 8, UART byte / RF data width
- ADDR_W, 8, RF address width
- RES_BYTES, 2, ALU result width in bytes (≥1); ALU result width = RES_BYTES*DATA_W
- FUN_W, 4, ALU function width (≤ DATA_W)
- TIMEOUT, 255, max cycles to wait for SC_RF_Valid / SC_ALU_Valid (≥1)

Ports:
- SC_CLK  in  1  system clock; single clock domain
- SC_RST  in  1  asynchronous, active-low reset
- SC_Cmd  in  3  command code: 001 WRITE, 010 READ, 100 ALU; all other codes are illegal
- SC_Cmd_Valid  in  1  command, data and address are valid this cycle
- SC_Pdata  in  DATA_W  write data (WRITE) or ALU function in [FUN_W-1:0] (ALU)
- SC_Addr  in  ADDR_W  RF address
- SC_RdData  in  DATA_W  RF read data
- SC_RF_Valid  in  1  RF read data valid
- SC_ALU_Out  in  RES_BYTES*DATA_W  ALU result
- SC_ALU_Valid  in  1  ALU result valid
- SC_TX_Busy  in  1  UART TX busy
- SC_Addr_Out  out  ADDR_W  RF address
- SC_Wr_Data  out  DATA_W  RF write data
- SC_Wr_En / SC_Rd_En  out  1  RF strobes
- SC_ALU_Fun  out  FUN_W  ALU function
- SC_ALU_En  out  1  ALU enable
- SC_Gate_En  out  1  ALU clock-gate enable
- SC_TX_Pdata  out  DATA_W  byte to transmit
- SC_TX_Valid  out  1  byte offered to TX
- SC_Cmd_Err  out  1  one-cycle pulse: illegal command or timeout
- SC_Idle  out  1  ready to accept a command; equals (state==IDLE) & !SC_TX_Busy

## Operation
- States: IDLE, WRITE, READ_WAIT, ALU_WAIT, SEND_OFFER, SEND_DRAIN.
- Command acceptance: a command is accepted only when SC_Idle=1 and SC_Cmd_Valid=1. In that cycle Cmd, Pdata and Addr are captured into registers. SC_Cmd_Valid is ignored in any other state.
- Illegal command: SC_Cmd_Err pulses for one cycle in the cycle after acceptance. The FSM stays in IDLE.
- WRITE: SC_Wr_En=1 for exactly one cycle, with the captured address and data on SC_Addr_Out / SC_Wr_Data. Then the FSM returns to IDLE. No TX traffic.
- READ_WAIT: SC_Rd_En=1 and SC_Addr_Out=captured address, held until SC_RF_Valid. On SC_RF_Valid, SC_RdData is captured into byte 0 of the result register, the byte count is set to 1, and the FSM goes to SEND_OFFER.
- ALU_WAIT: SC_ALU_En=1, SC_Gate_En=1, SC_ALU_Fun=captured Pdata[FUN_W-1:0], held until SC_ALU_Valid. On SC_ALU_Valid, SC_ALU_Out is captured, the byte count is set to RES_BYTES, and the FSM goes to SEND_OFFER.
- Timeout: a wait counter clears on entry to READ_WAIT or ALU_WAIT. If it reaches TIMEOUT without the matching valid, SC_Cmd_Err pulses, the FSM returns to IDLE, and nothing is transmitted.
- SEND_OFFER: SC_TX_Valid=1 and SC_TX_Pdata=result byte[idx], starting at idx 0 (LS byte first). Both are held until SC_TX_Busy is sampled 1 (byte accepted). The FSM then goes to SEND_DRAIN.
- SEND_DRAIN: SC_TX_Valid=0; wait for SC_TX_Busy=0. Then idx increments. If idx equals the byte count, the FSM returns to IDLE; otherwise it returns to SEND_OFFER.
- Gate enable during sends: SC_Gate_En stays 1 through both SEND states for ALU commands and is 0 for READ.
- Result register width is RES_BYTES*DATA_W. READ uses only byte 0.

## Timing
- Reset: SC_RST low asynchronously forces IDLE, clears idx, wait counter and captured registers, and drives all outputs to 0. The exception is SC_Idle, which follows !SC_TX_Busy. Reset mid-send aborts with no further SC_TX_Valid.
- WRITE latency: accept at cycle N; SC_Wr_En high in N+1 only; SC_Idle high again from N+2 (if TX not busy).
- READ/ALU: strobes assert from N+1. The valid is sampled at cycle M; SC_TX_Valid asserts from M+1.
- Byte to byte: TX_Busy rising is followed by TX_Valid low in the next cycle. TX_Busy falling is followed by the next TX_Valid one cycle later.
- Simultaneous SC_RF_Valid/SC_ALU_Valid and timeout in the same cycle: the valid wins.
- SC_Cmd_Err is never asserted together with SC_TX_Valid.

## Structure
- Package sys_ctrl_pkg holds the command codes (CMD_WRITE, CMD_READ, CMD_ALU) and the state encoding.
- Sub-module sc_byte_serialiser, parametrised by DATA_W and RES_BYTES. It contains the result register, idx, and the SEND_OFFER/SEND_DRAIN handshake. It has a start/count input and a done output.
- The top level holds the command FSM and the wait counter.

## Test plan
- WRITE Addr=0x05, Pdata=0xA7 -> SC_Wr_En is one cycle at N+1 with Addr_Out=0x05, Wr_Data=0xA7; TX_Valid never asserts.
- READ Addr=0x03, RF_Valid after 3 cycles with RdData=0x3C -> Rd_En high for 3 cycles; one TX byte 0x3C; back to IDLE.
- ALU Pdata=0x02, ALU_Out=0x12F4 (RES_BYTES=2), TX busy 10 cycles per byte -> TX bytes 0xF4 then 0x12; Gate_En held through both bytes; ALU_Fun=2.
- RES_BYTES=3, DATA_W=8, ALU_Out=0xABCDEF -> bytes 0xEF, 0xCD, 0xAB in order.
- Cmd=3'b111 -> one-cycle Cmd_Err and no strobes; READ with RF_Valid never asserted and TIMEOUT=16 -> Cmd_Err after 16 cycles, then IDLE.
- Reset pulsed during the second byte's SEND_OFFER -> all outputs 0 immediately; after release, SC_Idle=1 and a new WRITE completes normally.
